// File: rtl/game_status_ctrl.sv
// HUD/status sequencer: round-robin arbitration of hit/kill events, health and score
// bookkeeping, IDLE/PLAY/OVER game flow and the game-over LED animation.
module game_status_ctrl #(
  parameter int         N_SRC       = 4,
  parameter int         SCORE_W     = 8,
  parameter logic [3:0] HEALTH_INIT = 4'd9,
  parameter int         ANIM_DIV    = 25_000_000
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [N_SRC-1:0]   ev_req,
  input  logic [N_SRC-1:0]   ev_kind,
  output logic [N_SRC-1:0]   ev_gnt,
  output logic [3:0]         ship_health,
  output logic [SCORE_W-1:0] current_score,
  output logic [SCORE_W-1:0] alltime_highscore,
  output logic [1:0]         game_state,
  output logic               game_over,
  output logic [17:0]        ledr,
  output logic [8:0]         ledg
);

  // state | meaning
  // IDLE  | waiting for start, requests ignored
  // PLAY  | arbitrating and applying events
  // OVER  | game finished, LED animation running
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  localparam int PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int DIV_W = $clog2(ANIM_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(ANIM_DIV - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

  state_t             state_q, state_d;
  logic [3:0]         health_q, health_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] hi_q, hi_d;
  logic [N_SRC-1:0]   gnt_q, gnt_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [1:0]         frame_q, frame_d;
  logic [DIV_W-1:0]   div_q, div_d;

  logic [N_SRC-1:0]   eligible;
  logic               found;
  logic [PTR_W-1:0]   win, cand, ptr_nxt;
  int                 cand_i;

  // ptr_q holds the index the search starts from (one past the last winner)
  always_comb begin
    eligible = ev_req & ~gnt_q;
    found    = 1'b0;
    win      = '0;
    cand     = '0;
    cand_i   = 0;
    for (int i = 0; i < N_SRC; i++) begin
      cand_i = int'(ptr_q) + i;
      if (cand_i >= N_SRC) cand_i = cand_i - N_SRC;
      cand = PTR_W'(cand_i);
      if (!found && eligible[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    if (win == PTR_W'(N_SRC - 1)) ptr_nxt = '0;
    else                          ptr_nxt = win + 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    health_d = health_q;
    score_d  = score_q;
    hi_d     = hi_q;
    gnt_d    = '0;
    ptr_d    = ptr_q;
    frame_d  = frame_q;
    div_d    = div_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_PLAY;
          health_d = HEALTH_INIT;
          score_d  = '0;
        end
      end
      ST_PLAY: begin
        if (found) begin
          gnt_d = N_SRC'(1) << win;
          ptr_d = ptr_nxt;
          if (ev_kind[win]) begin
            if (score_q != SCORE_MAX) score_d = score_q + 1'b1;
          end else if (health_q <= 4'd1) begin
            health_d = '0;
            state_d  = ST_OVER;
            hi_d     = (score_q > hi_q) ? score_q : hi_q;
            frame_d  = '0;
            div_d    = '0;
          end else begin
            health_d = health_q - 4'd1;
          end
        end
      end
      ST_OVER: begin
        if (start) begin
          state_d  = ST_PLAY;
          health_d = HEALTH_INIT;
          score_d  = '0;
          frame_d  = '0;
          div_d    = '0;
        end else if (div_q == DIV_LAST) begin
          div_d   = '0;
          frame_d = frame_q + 2'd1;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      health_q <= HEALTH_INIT;
      score_q  <= '0;
      hi_q     <= '0;
      gnt_q    <= '0;
      ptr_q    <= '0;
      frame_q  <= '0;
      div_q    <= '0;
    end else begin
      state_q  <= state_d;
      health_q <= health_d;
      score_q  <= score_d;
      hi_q     <= hi_d;
      gnt_q    <= gnt_d;
      ptr_q    <= ptr_d;
      frame_q  <= frame_d;
      div_q    <= div_d;
    end
  end

  // LEDs are dark outside OVER, so reset and restart clear them for free
  always_comb begin
    ledr = '0;
    ledg = '0;
    if (state_q == ST_OVER) begin
      case (frame_q)
        2'd0: begin ledr = 18'b101010101010101010; ledg = 9'b101010101; end
        2'd1: begin ledr = 18'b100010001000100010; ledg = 9'b100010001; end
        2'd2: begin ledr = 18'b100000001000000010; ledg = 9'b100000001; end
        default: begin ledr = '0; ledg = '0; end
      endcase
    end
  end

  assign ev_gnt            = gnt_q;
  assign ship_health       = health_q;
  assign current_score     = score_q;
  assign alltime_highscore = hi_q;
  assign game_state        = state_q;
  assign game_over         = (state_q == ST_OVER);

endmodule

// File: tb/tb_game_status_ctrl.sv
// Bench for game_status_ctrl: directed vector table, hand-written game sequences and
// randomized play checked cycle-by-cycle against a rule-level reference model.
module tb_game_status_ctrl;
  localparam int N    = 4;
  localparam int SW   = 3;
  localparam int HI   = 9;
  localparam int AD   = 4;
  localparam int SMAX = (1 << SW) - 1;

  localparam logic [17:0] FR [4] = '{18'b101010101010101010, 18'b100010001000100010,
                                     18'b100000001000000010, 18'b0};
  localparam logic [8:0]  FG [4] = '{9'b101010101, 9'b100010001, 9'b100000001, 9'b0};

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic [N-1:0]  ev_req = '0;
  logic [N-1:0]  ev_kind = '0;
  logic [N-1:0]  ev_gnt;
  logic [3:0]    ship_health;
  logic [SW-1:0] current_score;
  logic [SW-1:0] alltime_highscore;
  logic [1:0]    game_state;
  logic          game_over;
  logic [17:0]   ledr;
  logic [8:0]    ledg;

  game_status_ctrl #(.N_SRC(N), .SCORE_W(SW), .HEALTH_INIT(4'(HI)), .ANIM_DIV(AD)) dut (
    .clk(clk), .resetn(resetn), .start(start), .ev_req(ev_req), .ev_kind(ev_kind),
    .ev_gnt(ev_gnt), .ship_health(ship_health), .current_score(current_score),
    .alltime_highscore(alltime_highscore), .game_state(game_state), .game_over(game_over),
    .ledr(ledr), .ledg(ledg));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: game rules in plain integers; animation frame derived from time in OVER
  int           m_state = 0, m_health = HI, m_score = 0, m_hi = 0, m_last = -1, m_over = 0;
  logic [N-1:0] m_gnt = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [N-1:0] elig;
    int idx;
    elig  = ev_req & ~m_gnt;
    m_gnt = '0;
    if (!resetn) begin
      m_state = 0; m_health = HI; m_score = 0; m_hi = 0; m_last = -1; m_over = 0;
    end else if (m_state == 0) begin
      if (start) begin m_state = 1; m_health = HI; m_score = 0; end
    end else if (m_state == 1) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_last + 1 + k) % N;
        if (elig[idx] && m_gnt == '0) begin
          m_gnt[idx] = 1'b1;
          m_last = idx;
          if (ev_kind[idx]) m_score = (m_score < SMAX) ? m_score + 1 : SMAX;
          else begin
            m_health = m_health - 1;
            if (m_health == 0) begin
              m_state = 2; m_over = 0;
              if (m_score > m_hi) m_hi = m_score;
            end
          end
        end
      end
    end else begin
      if (start) begin m_state = 1; m_health = HI; m_score = 0; end
      else m_over++;
    end
  endtask

  task automatic tick();
    logic [17:0] er;
    logic [8:0]  eg;
    model_step();
    @(posedge clk);
    #1;
    er = (m_state == 2) ? FR[(m_over / AD) % 4] : '0;
    eg = (m_state == 2) ? FG[(m_over / AD) % 4] : '0;
    check("m_gnt",    32'(ev_gnt),            32'(m_gnt));
    check("m_health", 32'(ship_health),       32'(m_health));
    check("m_score",  32'(current_score),     32'(m_score));
    check("m_hi",     32'(alltime_highscore), 32'(m_hi));
    check("m_state",  32'(game_state),        32'(m_state));
    check("m_over",   32'(game_over),         32'(m_state == 2));
    check("m_ledr",   32'(ledr),              32'(er));
    check("m_ledg",   32'(ledg),              32'(eg));
  endtask

  typedef struct {
    logic         rst_n;
    logic         st;
    logic [N-1:0] req;
    logic [N-1:0] kind;
    logic [N-1:0] gnt;
    int           score;
    int           health;
    int           state;
    int           hi;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic r, input logic s, input logic [N-1:0] q, input logic [N-1:0] k,
                     input logic [N-1:0] g, input int sc, input int h, input int st, input int hs);
    vec_t v;
    v.rst_n = r; v.st = s; v.req = q; v.kind = k; v.gnt = g;
    v.score = sc; v.health = h; v.state = st; v.hi = hs;
    tbl.push_back(v);
  endtask

  initial begin
    // rst st  req      kind     gnt      sc h  st hi
    add(0, 1, 4'b0000, 4'b0000, 4'b0000, 0, 9, 0, 0);
    add(1, 0, 4'b0000, 4'b0000, 4'b0000, 0, 9, 0, 0);
    add(1, 1, 4'b0000, 4'b0000, 4'b0000, 0, 9, 1, 0);
    add(1, 0, 4'b0001, 4'b0001, 4'b0001, 1, 9, 1, 0);
    add(1, 0, 4'b0000, 4'b0000, 4'b0000, 1, 9, 1, 0);
    add(1, 0, 4'b0001, 4'b0001, 4'b0001, 2, 9, 1, 0);
    add(1, 0, 4'b0000, 4'b0000, 4'b0000, 2, 9, 1, 0);
    add(1, 0, 4'b0001, 4'b0001, 4'b0001, 3, 9, 1, 0);
    add(1, 0, 4'b0000, 4'b0000, 4'b0000, 3, 9, 1, 0);
    add(0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 9, 0, 0);
    add(1, 1, 4'b0000, 4'b0000, 4'b0000, 0, 9, 1, 0);
    add(1, 0, 4'b1111, 4'b1111, 4'b0001, 1, 9, 1, 0);
    add(1, 0, 4'b1110, 4'b1111, 4'b0010, 2, 9, 1, 0);
    add(1, 0, 4'b1100, 4'b1111, 4'b0100, 3, 9, 1, 0);
    add(1, 0, 4'b1000, 4'b1111, 4'b1000, 4, 9, 1, 0);
    add(1, 0, 4'b0000, 4'b0000, 4'b0000, 4, 9, 1, 0);
    add(1, 0, 4'b0100, 4'b0000, 4'b0100, 4, 8, 1, 0);
    add(1, 0, 4'b0000, 4'b0000, 4'b0000, 4, 8, 1, 0);
    add(1, 0, 4'b0011, 4'b0001, 4'b0001, 5, 8, 1, 0);
    add(1, 0, 4'b0010, 4'b0000, 4'b0010, 5, 7, 1, 0);
    add(1, 1, 4'b0000, 4'b0000, 4'b0000, 5, 7, 1, 0);
    add(1, 0, 4'b0000, 4'b0000, 4'b0000, 5, 7, 1, 0);

    for (int r = 0; r < tbl.size(); r++) begin
      resetn = tbl[r].rst_n; start = tbl[r].st; ev_req = tbl[r].req; ev_kind = tbl[r].kind;
      tick();
      check("tbl_gnt",    32'(ev_gnt),            32'(tbl[r].gnt));
      check("tbl_score",  32'(current_score),     32'(tbl[r].score));
      check("tbl_health", 32'(ship_health),       32'(tbl[r].health));
      check("tbl_state",  32'(game_state),        32'(tbl[r].state));
      check("tbl_hi",     32'(alltime_highscore), 32'(tbl[r].hi));
    end

    // hits from src2 until game over (health 7 -> 0), score 5 becomes the high score
    for (int k = 1; k <= 7; k++) begin
      ev_req = 4'b0100; ev_kind = 4'b0000;
      tick();
      check("hit_gnt",    32'(ev_gnt),      32'h4);
      check("hit_health", 32'(ship_health), 32'(7 - k));
      check("hit_state",  32'(game_state),  (k == 7) ? 32'd2 : 32'd1);
      ev_req = '0;
      if (k < 7) tick();
    end
    check("over_flag", 32'(game_over),         32'd1);
    check("over_hi",   32'(alltime_highscore), 32'd5);
    check("over_f0",   32'(ledr),              32'(FR[0]));

    // animation with requests held: no grants, frames advance every AD cycles
    ev_req = 4'b1111; ev_kind = 4'b1010;
    for (int t = 1; t <= 21; t++) begin
      tick();
      check("anim_ledr", 32'(ledr),   32'(FR[(t / AD) % 4]));
      check("anim_ledg", 32'(ledg),   32'(FG[(t / AD) % 4]));
      check("anim_gnt",  32'(ev_gnt), 32'd0);
    end

    // reset while F1 is showing, start in the same cycle is ignored
    resetn = 1'b0; start = 1'b1; ev_req = '0;
    tick();
    check("rst_state",  32'(game_state),        32'd0);
    check("rst_ledr",   32'(ledr),              32'd0);
    check("rst_hi",     32'(alltime_highscore), 32'd0);
    check("rst_health", 32'(ship_health),       32'd9);

    // saturation: 9 kills on a 3-bit score stop at 7
    resetn = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 9; k++) begin
      ev_req = 4'b0010; ev_kind = 4'b0010; tick();
      ev_req = '0; tick();
    end
    check("sat_score", 32'(current_score), 32'd7);
    for (int k = 0; k < 9; k++) begin
      ev_req = 4'b1000; ev_kind = 4'b0000; tick();
      ev_req = '0; tick();
    end
    check("sat_over", 32'(game_state),        32'd2);
    check("sat_hi",   32'(alltime_highscore), 32'd7);

    // lower-scoring game keeps the high score
    start = 1'b1; tick(); start = 1'b0;
    check("restart_score", 32'(current_score), 32'd0);
    check("restart_ledr",  32'(ledr),          32'd0);
    for (int k = 0; k < 2; k++) begin
      ev_req = 4'b0001; ev_kind = 4'b0001; tick();
      ev_req = '0; tick();
    end
    for (int k = 0; k < 9; k++) begin
      ev_req = 4'b0001; ev_kind = 4'b0000; tick();
      ev_req = '0; tick();
    end
    check("low_score", 32'(current_score),     32'd2);
    check("low_hi",    32'(alltime_highscore), 32'd7);
    check("low_state", 32'(game_state),        32'd2);

    // randomized play; requesters follow the hold-until-granted protocol
    for (int c = 0; c < 4000; c++) begin
      resetn = ($urandom_range(0, 299) != 0);
      start  = ($urandom_range(0, 19) == 0);
      tick();
      for (int i = 0; i < N; i++) begin
        if (ev_req[i] && m_gnt[i]) ev_req[i] = 1'b0;
        else if (!ev_req[i] && $urandom_range(0, 2) == 0) begin
          ev_req[i]  = 1'b1;
          ev_kind[i] = 1'($urandom_range(0, 1));
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
